// File: rtl/apb_timer_slave_if.sv
// APB4 completer bus bundle for the timer slave.
// Master drives request fields; slave drives the response.
interface apb_timer_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [3:0]            PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_slave.sv
// APB4 down-counting timer: prescaler, auto-reload, IRQ.
// Bus FSM inserts WAIT_STATES wait cycles per access.
module apb_timer_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_timer_slave_if.slave  apb,
  output logic              TIMER_IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] WLAST =
    2'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_LOAD = 5'h04;
  localparam logic [4:0] A_CNT  = 5'h08;
  localparam logic [4:0] A_STAT = 5'h0C;
  localparam logic [4:0] A_PRE  = 5'h10;

  state_t state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;

  logic [4:0]            addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            strb_q;

  logic                  en_q, en_d;
  logic                  arl_q, arl_d;
  logic                  irqen_q, irqen_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  expired_q, expired_d;
  logic [7:0]            presc_q, presc_d;
  logic [7:0]            pcnt_q, pcnt_d;

  logic                  unused_addr;
  logic                  setup;
  logic                  done;
  logic                  err;
  logic                  commit;
  logic                  wr_ctrl, wr_load;
  logic                  wr_stat, wr_pre;
  logic                  tick, expire;
  logic [DATA_WIDTH-1:0] load_m;
  logic [DATA_WIDTH-1:0] rd_mux;

  // Upper address bits are deliberately not decoded.
  assign unused_addr = ^apb.PADDR;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] o,
    input logic [DATA_WIDTH-1:0] w,
    input logic [3:0]            s
  );
    logic [DATA_WIDTH-1:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[8*i +: 8] = w[8*i +: 8];
    end
    return r;
  endfunction

  assign setup = apb.PSEL && !apb.PENABLE;

  // Bus FSM next state: IDLE -> WAIT -> DONE, PSEL drop aborts.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          wcnt_d  = 2'd0;
          state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!apb.PSEL) begin
          state_d = S_IDLE;
        end else if (apb.PENABLE) begin
          if (wcnt_q == WLAST) state_d = S_DONE;
          else                 wcnt_d  = wcnt_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus FSM state and wait counter registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Capture the request during the setup phase.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (state_q == S_IDLE && setup) begin
      addr_q  <= apb.PADDR[4:0];
      write_q <= apb.PWRITE;
      wdata_q <= apb.PWDATA;
      strb_q  <= apb.PSTRB;
    end
  end

  assign done = (state_q == S_DONE) && apb.PSEL;

  assign err = (addr_q[1:0] != 2'b00) ||
               (addr_q > A_PRE) ||
               (write_q && addr_q == A_CNT);

  assign commit  = done && write_q && !err;
  assign wr_ctrl = commit && addr_q == A_CTRL && strb_q[0];
  assign wr_load = commit && addr_q == A_LOAD;
  assign wr_stat = commit && addr_q == A_STAT &&
                   strb_q[0] && wdata_q[0];
  assign wr_pre  = commit && addr_q == A_PRE && strb_q[0];
  assign load_m  = merge(load_q, wdata_q, strb_q);

  assign tick   = en_q && (pcnt_q == presc_q);
  assign expire = tick && (count_q == '0);

  // Timer next state; ticks use pre-write control bits.
  always_comb begin
    en_d      = en_q;
    arl_d     = arl_q;
    irqen_d   = irqen_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;

    if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;

    if (tick) begin
      if (count_q != '0)  count_d = count_q - 1'b1;
      else if (arl_q)     count_d = load_q;
      else                count_d = '0;
    end else if (wr_load && !en_q) begin
      count_d = load_m;
    end

    if (expire && !arl_q) en_d = 1'b0;

    if (wr_ctrl) begin
      en_d    = wdata_q[0];
      arl_d   = wdata_q[1];
      irqen_d = wdata_q[2];
      if (wdata_q[0] && !en_q) pcnt_d = 8'd0;
    end

    if (wr_load) load_d = load_m;
    if (wr_pre)  presc_d = wdata_q[7:0];

    if (expire)       expired_d = 1'b1;
    else if (wr_stat) expired_d = 1'b0;
  end

  // Timer and register-file state.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en_q      <= 1'b0;
      arl_q     <= 1'b0;
      irqen_q   <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
    end else begin
      en_q      <= en_d;
      arl_q     <= arl_d;
      irqen_q   <= irqen_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
    end
  end

  // Read mux over pre-commit register state.
  always_comb begin
    rd_mux = '0;
    unique case (addr_q)
      A_CTRL:  rd_mux[2:0] = {irqen_q, arl_q, en_q};
      A_LOAD:  rd_mux      = load_q;
      A_CNT:   rd_mux      = count_q;
      A_STAT:  rd_mux[0]   = expired_q;
      A_PRE:   rd_mux[7:0] = presc_q;
      default: rd_mux      = '0;
    endcase
  end

  assign apb.PREADY  = done;
  assign apb.PSLVERR = done && err;
  assign apb.PRDATA  = (done && !write_q && !err) ? rd_mux : '0;
  assign TIMER_IRQ   = expired_q && irqen_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave with a response scoreboard.
// Driver queues expected responses; monitor checks on PREADY.
module tb_apb_timer_slave;

  localparam int WS = 1;

  logic PCLK;
  logic PRESET;
  logic TIMER_IRQ;

  apb_timer_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_timer_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .WAIT_STATES(WS)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (bus),
    .TIMER_IRQ(TIMER_IRQ)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Monitor: every completed transfer must match the queue head.
  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESET && bus.PREADY) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready: PADDR=%h PREADY=1, required no completion",
                 bus.PADDR);
      end else begin
        e = sbq.pop_front();
        if (bus.PRDATA !== e.rd || bus.PSLVERR !== e.err) begin
          errors++;
          $display("FAIL resp@%h: PRDATA=%h PSLVERR=%b, required %h/%b",
                   e.addr, bus.PRDATA, bus.PSLVERR, e.rd, e.err);
        end
      end
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_rd, input logic exp_err);
    int   n;
    logic got;
    exp_t dummy;
    sbq.push_back('{exp_rd, exp_err, addr});
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    bus.PSTRB   = strb;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge PCLK);
      n++;
      if (bus.PREADY) got = 1'b1;
      else begin
        @(posedge PCLK); #1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout@%h: no PREADY after %0d access cycles", addr, n);
      dummy = sbq.pop_back();
    end else if (n != WS + 1) begin
      errors++;
      $display("FAIL latency@%h: %0d access cycles, required %0d",
               addr, n, WS + 1);
    end
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd,
                    input logic exp_err);
    xfer(1'b0, addr, 32'h0, 4'h0, exp_rd, exp_err);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic exp_err);
    xfer(1'b1, addr, data, strb, 32'h0, exp_err);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_irq(input logic exp);
    @(negedge PCLK);
    chk("irq", {31'b0, TIMER_IRQ}, {31'b0, exp});
    @(posedge PCLK); #1;
  endtask

  // Setup phase then PSEL drops during the wait state.
  task automatic abort_wr(input logic [31:0] addr, input logic [31:0] data);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    bus.PSTRB   = 4'hF;
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    PRESET      = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", {31'b0, bus.PREADY}, 32'h0);
    chk("rst_pslverr", {31'b0, bus.PSLVERR}, 32'h0);
    chk("rst_prdata", bus.PRDATA, 32'h0);
    chk("rst_irq", {31'b0, TIMER_IRQ}, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Reset values at every offset.
    rd(32'h00, 32'h0, 1'b0);
    rd(32'h04, 32'h0, 1'b0);
    rd(32'h08, 32'h0, 1'b0);
    rd(32'h0C, 32'h0, 1'b0);
    rd(32'h10, 32'h0, 1'b0);
    chk_irq(1'b0);

    // Auto-reload countdown; reads land 3 cycles apart.
    wr(32'h04, 32'h3, 4'hF, 1'b0);
    wr(32'h10, 32'h0, 4'hF, 1'b0);
    wr(32'h00, 32'h7, 4'hF, 1'b0);
    rd(32'h08, 32'h1, 1'b0);
    rd(32'h08, 32'h2, 1'b0);
    rd(32'h08, 32'h3, 1'b0);
    rd(32'h08, 32'h0, 1'b0);
    rd(32'h0C, 32'h1, 1'b0);
    chk_irq(1'b1);

    // One-shot with prescale 1.
    wr(32'h00, 32'h0, 4'hF, 1'b0);
    wr(32'h0C, 32'h1, 4'h1, 1'b0);
    rd(32'h0C, 32'h0, 1'b0);
    chk_irq(1'b0);
    wr(32'h10, 32'h1, 4'hF, 1'b0);
    wr(32'h04, 32'h2, 4'hF, 1'b0);
    wr(32'h00, 32'h1, 4'hF, 1'b0);
    rd(32'h08, 32'h1, 1'b0);
    rd(32'h08, 32'h0, 1'b0);
    rd(32'h00, 32'h0, 1'b0);
    rd(32'h0C, 32'h1, 1'b0);
    rd(32'h08, 32'h0, 1'b0);
    chk_irq(1'b0);

    // Byte-lane merge on LOAD, copied into COUNT while disabled.
    wr(32'h04, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(32'h04, 32'h1234_5678, 4'b0010, 1'b0);
    rd(32'h04, 32'hFFFF_56FF, 1'b0);
    rd(32'h08, 32'hFFFF_56FF, 1'b0);

    // Illegal accesses leave all registers untouched.
    rd(32'h14, 32'h0, 1'b1);
    rd(32'h02, 32'h0, 1'b1);
    wr(32'h08, 32'h5, 4'hF, 1'b1);
    wr(32'h14, 32'h5, 4'hF, 1'b1);
    wr(32'h01, 32'h7, 4'hF, 1'b1);
    rd(32'h00, 32'h0, 1'b0);
    rd(32'h04, 32'hFFFF_56FF, 1'b0);
    rd(32'h08, 32'hFFFF_56FF, 1'b0);
    rd(32'h10, 32'h1, 1'b0);
    rd(32'h0C, 32'h1, 1'b0);

    // Expiry lands in the same cycle as the W1C commit.
    wr(32'h0C, 32'h1, 4'h1, 1'b0);
    rd(32'h0C, 32'h0, 1'b0);
    wr(32'h10, 32'h0, 4'hF, 1'b0);
    wr(32'h04, 32'h2, 4'hF, 1'b0);
    wr(32'h00, 32'h3, 4'hF, 1'b0);
    wr(32'h0C, 32'h1, 4'h1, 1'b0);
    rd(32'h0C, 32'h1, 1'b0);
    wr(32'h00, 32'h0, 4'hF, 1'b0);

    // Aborted write must not commit or complete.
    abort_wr(32'h04, 32'hDEAD_BEEF);
    rd(32'h04, 32'h2, 1'b0);
    chk("sb_empty", sbq.size(), 32'h0);

    repeat (3) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
